branch_resolve_unit: RTL

Parametrised branch resolution stage for the RAT pipeline. It evaluates the branch-type code against C/Z, produces the taken flag and the redirect PC, and owns the return-address stack (RAS), the interrupt-enable bit and the interrupt flag shadow. It sits in the execute stage and feeds the fetch redirect mux and flag register.

---
 rtl/rat_branch_pkg.sv | 38 +++
 rtl/return_addr_stack.sv | 62 ++++++
 rtl/branch_resolve_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rat_branch_pkg.sv
// Shared encodings for the RAT branch resolution stage.
// Branch-type codes, default interrupt vector and the condition helper.
package rat_branch_pkg;

   localparam logic [3:0] BT_NONE  = 4'h0;
   localparam logic [3:0] BT_BRCC  = 4'h1;
   localparam logic [3:0] BT_BRCS  = 4'h2;
   localparam logic [3:0] BT_BREQ  = 4'h3;
   localparam logic [3:0] BT_BRN   = 4'h4;
   localparam logic [3:0] BT_BRNE  = 4'h5;
   localparam logic [3:0] BT_CALL  = 4'h6;
   localparam logic [3:0] BT_RET   = 4'h7;
   localparam logic [3:0] BT_RETID = 4'h8;
   localparam logic [3:0] BT_RETIE = 4'h9;
   localparam logic [3:0] BT_SEI   = 4'hA;
   localparam logic [3:0] BT_CLI   = 4'hB;

   localparam logic [9:0] DEF_INT_VECTOR = 10'h3FF;

   // Only meaningful for the four conditional types.
   function automatic logic cond_taken(
      input logic [3:0] bt,
      input logic       c,
      input logic       z
   );
      logic t;
      t = 1'b0;
      case (bt)
         BT_BRCC: t = ~c;
         BT_BRCS: t = c;
         BT_BREQ: t = z;
         BT_BRNE: t = ~z;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack with write pointer and saturating count.
// A push when full overwrites the oldest entry; a pop when empty is ignored.
module return_addr_stack
   import rat_branch_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int RAS_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic              full,
   output logic              empty
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
   logic [PW-1:0]     wp_q;
   logic [PW-1:0]     wp_d;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     cnt_d;

   assign full  = (cnt_q == CW'(RAS_DEPTH));
   assign empty = (cnt_q == '0);
   assign top   = mem_q[wp_q - PW'(1)];

   always_comb begin
      wp_d  = wp_q;
      cnt_d = cnt_q;
      if (push) begin
         wp_d = wp_q + PW'(1);
         if (!full) begin
            cnt_d = cnt_q + CW'(1);
         end
      end else if (pop && !empty) begin
         wp_d  = wp_q - PW'(1);
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wp_q  <= wp_d;
         cnt_q <= cnt_d;
         if (push) begin
            mem_q[wp_q] <= push_data;
         end
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: condition evaluation, redirect PC,
// return-address stack, interrupt entry, IE and flag shadow.
module branch_resolve_unit
   import rat_branch_pkg::*;
#(
   parameter int                ADDR_W     = 10,
   parameter int                RAS_DEPTH  = 8,
   parameter logic [ADDR_W-1:0] INT_VECTOR = ADDR_W'(DEF_INT_VECTOR)
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              VALID,
   input  logic [3:0]        BRANCH_TYPE,
   input  logic              C,
   input  logic              Z,
   input  logic [ADDR_W-1:0] PC,
   input  logic [ADDR_W-1:0] TARGET,
   input  logic              INT_REQ,
   output logic              BRANCH_TAKEN,
   output logic [ADDR_W-1:0] BRANCH_PC,
   output logic              INT_ACK,
   output logic              IE,
   output logic              FLAG_RESTORE,
   output logic              SHADOW_C,
   output logic              SHADOW_Z,
   output logic              RAS_OVF,
   output logic              RAS_UNF
);

   logic              ie_q, ie_d;
   logic              shc_q, shc_d;
   logic              shz_q, shz_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              ras_push;
   logic              ras_pop;
   logic [ADDR_W-1:0] ras_wdata;
   logic [ADDR_W-1:0] ras_top;
   logic              ras_full;
   logic              ras_empty;

   return_addr_stack #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (CLK),
      .rst_n     (RST_N),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (ras_wdata),
      .top       (ras_top),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   always_comb begin
      BRANCH_TAKEN = 1'b0;
      BRANCH_PC    = '0;
      INT_ACK      = 1'b0;
      FLAG_RESTORE = 1'b0;
      ras_push     = 1'b0;
      ras_pop      = 1'b0;
      ras_wdata    = PC + ADDR_W'(1);
      ie_d         = ie_q;
      shc_d        = shc_q;
      shz_d        = shz_q;
      ovf_d        = ovf_q;
      unf_d        = unf_q;

      // Interrupt wins; the abandoned instruction re-executes on return.
      if (VALID && INT_REQ && ie_q) begin
         INT_ACK      = 1'b1;
         BRANCH_TAKEN = 1'b1;
         BRANCH_PC    = INT_VECTOR;
         ras_push     = 1'b1;
         ras_wdata    = PC;
         shc_d        = C;
         shz_d        = Z;
         ie_d         = 1'b0;
      end else if (VALID) begin
         case (BRANCH_TYPE)
            BT_BRCC, BT_BRCS, BT_BREQ, BT_BRNE: begin
               BRANCH_TAKEN = cond_taken(BRANCH_TYPE, C, Z);
               BRANCH_PC    = TARGET;
            end
            BT_BRN: begin
               BRANCH_TAKEN = 1'b1;
               BRANCH_PC    = TARGET;
            end
            BT_CALL: begin
               BRANCH_TAKEN = 1'b1;
               BRANCH_PC    = TARGET;
               ras_push     = 1'b1;
            end
            BT_RET, BT_RETID, BT_RETIE: begin
               BRANCH_TAKEN = 1'b1;
               ras_pop      = 1'b1;
               BRANCH_PC    = ras_empty ? '0 : ras_top;
               if (ras_empty) begin
                  unf_d = 1'b1;
               end
               if (BRANCH_TYPE == BT_RETID) begin
                  ie_d         = 1'b0;
                  FLAG_RESTORE = 1'b1;
               end
               if (BRANCH_TYPE == BT_RETIE) begin
                  ie_d         = 1'b1;
                  FLAG_RESTORE = 1'b1;
               end
            end
            BT_SEI:  ie_d = 1'b1;
            BT_CLI:  ie_d = 1'b0;
            default: ;
         endcase
      end

      if (ras_push && ras_full) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ie_q  <= 1'b0;
         shc_q <= 1'b0;
         shz_q <= 1'b0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ie_q  <= ie_d;
         shc_q <= shc_d;
         shz_q <= shz_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign IE       = ie_q;
   assign SHADOW_C = shc_q;
   assign SHADOW_Z = shz_q;
   assign RAS_OVF  = ovf_q;
   assign RAS_UNF  = unf_q;

endmodule
